// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spm_pkg;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} spm_ctrl_state_t;

  // Number of RUN cycles: 2*size product bits plus the core's pipeline depth.
  function automatic int run_len(input int size, input int core_lat);
    return 2 * size + core_lat;
  endfunction

endpackage

// File: rtl/spm_prod_capture.sv
// Right-shift capture register collecting the serial product, LSB arriving first.
// Latency: one bit per enabled cycle; a full product needs 2*SIZE enabled cycles.
// Backpressure: none; the sequencer decides when shift_en is asserted.
module spm_prod_capture #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [2*SIZE-1:0] prod
);

  // New bits enter at the MSB; after 2*SIZE shifts the first bit sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
    end else if (shift_en) begin
      prod <= {bit_in, prod[2*SIZE-1:1]};
    end
  end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer: accepts {x,y}, streams y LSB-first into the spm core, captures the serial product.
// Latency: accept to out_valid = 2*SIZE+CORE_LAT+2 cycles; one multiply in flight.
// Backpressure: in_ready only in IDLE; product held until out_ready. Build macro SPM_SEQ_CTRL_SIGNED_EN.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int CORE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_x,
  input  logic [SIZE-1:0]   in_y,
  output logic              core_rst,
  output logic [SIZE-1:0]   core_x,
  output logic              core_y,
  input  logic              core_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_p,
  output logic              busy
);

  localparam int RUN_LEN = run_len(SIZE, CORE_LAT);
  // Wide enough to hold RUN_LEN itself, so the final increment never wraps.
  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CORE_LAT);

  spm_ctrl_state_t  state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  y_sh;
  logic             y_fill;
  logic             shift_en;

  // Bit shifted into the top of y_sh: sign extension in the signed build, zero otherwise.
`ifdef SPM_SEQ_CTRL_SIGNED_EN
  assign y_fill = y_sh[SIZE-1];
`else
  assign y_fill = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/core control decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_rst  = 1'b1;
    core_y    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = CLR;
      end
      CLR: begin
        state_nxt = RUN;
      end
      RUN: begin
        core_rst = rst;
        core_y   = y_sh[0];
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = !rst;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, y shifter and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_x <= '0;
      y_sh   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            core_x <= in_x;
            y_sh   <= in_y;
          end
        end
        CLR: cnt <= '0;
        RUN: begin
          y_sh <= {y_fill, y_sh[SIZE-1:1]};
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The core output lags core_y by CORE_LAT cycles, so capture starts that late.
  assign shift_en = (state == RUN) && (cnt >= CNT_CAP);

  spm_prod_capture #(.SIZE(SIZE)) u_capture (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (core_p),
    .prod     (out_p)
  );

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Self-checking bench for spm_seq_ctrl with a behavioural serial multiplier core.
// Latency: checks accept-to-out_valid of 2*SIZE+CORE_LAT+2 on every operation.
// Backpressure: exercises out_ready hold, back-to-back accepts and ignored in_valid.
module tb_spm_seq_ctrl;

  localparam int SIZE     = 8;
  localparam int CORE_LAT = 1;
  localparam int PW       = 2 * SIZE;
  localparam int W        = 2 * SIZE + 2;
  localparam int LAT      = 2 * SIZE + CORE_LAT + 2;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SIZE-1:0] in_x;
  logic [SIZE-1:0] in_y;
  logic          core_rst;
  logic [SIZE-1:0] core_x;
  logic          core_y;
  logic          core_p;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;
  logic          busy;

  always #5 clk = ~clk;

  spm_seq_ctrl #(.SIZE(SIZE), .CORE_LAT(CORE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .core_rst  (core_rst),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_p    (core_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  // Behavioural core: serial accumulate of x*y_k, emitting one product bit per cycle.
  logic [W-1:0] acc;
  logic [W-1:0] xext;
  logic [W-1:0] tsum;
  logic         p_reg;

  always_comb xext = {{(W - SIZE){SGN & core_x[SIZE-1]}}, core_x};
  always_comb tsum = acc + (core_y ? xext : '0);
  always @(posedge clk) begin
    if (core_rst) begin
      acc   <= '0;
      p_reg <= 1'b0;
    end else begin
      p_reg <= tsum[0];
      acc   <= {SGN & tsum[W-1], tsum[W-1:1]};
    end
  end
  assign core_p = p_reg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard state.
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] cur_exp;
  int  acc_count = 0;
  int  out_count = 0;
  int  acc_cyc = 0;
  bit  acc_pend = 1'b0;
  bit  prev_ov = 1'b0;

  // Monitor: push on accept, pop and compare on product handshake, check latency.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_pend = 1'b0;
      prev_ov  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_count++;
        acc_cyc  = cyc;
        acc_pend = 1'b1;
      end
      if (out_valid && !prev_ov && acc_pend) begin
        check("latency", 64'(cyc - acc_cyc), 64'(LAT));
        acc_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=no_output", out_p);
        end else begin
          check("product", 64'(out_p), 64'(exp_q.pop_front()));
        end
        out_count++;
      end
      prev_ov = out_valid;
    end
  end

  // Offer a pair and return just after the handshake edge.
  task automatic accept_op(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y, input logic [PW-1:0] e);
    int n;
    in_x     = x;
    in_y     = y;
    cur_exp  = e;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_in_ready required=in_ready");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outs(input int target);
    int n;
    n = 0;
    while (out_count < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_count", 64'(out_count), 64'(target));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [SIZE-1:0] x;
    logic [SIZE-1:0] y;
    logic [PW-1:0]   exp_u;
    logic [PW-1:0]   exp_s;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [PW-1:0] pick(input logic [PW-1:0] eu, input logic [PW-1:0] es);
    return SGN ? es : eu;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int total;
    int a0;
    int seen;
    logic [PW-1:0] e;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1; cur_exp = '0;
    tbl[0] = '{8'h03, 8'h05, 16'h000F, 16'h000F};
    tbl[1] = '{8'hFD, 8'h05, 16'h04F1, 16'hFFF1};
    tbl[2] = '{8'h80, 8'h80, 16'h4000, 16'h4000};
    tbl[3] = '{8'h7F, 8'h81, 16'h3FFF, 16'hC0FF};
    tbl[4] = '{8'h0B, 8'h0D, 16'h008F, 16'h008F};
    total = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_core_x", 64'(core_x), 64'(0));
    check("rst_core_y", 64'(core_y), 64'(0));
    check("rst_out_p", 64'(out_p), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // Table-driven single operations.
    for (int i = 0; i < 5; i++) begin
      accept_op(tbl[i].x, tbl[i].y, pick(tbl[i].exp_u, tbl[i].exp_s));
      in_valid = 1'b0;
      total++;
      wait_outs(total);
    end

    // Output held under backpressure.
    out_ready = 1'b0;
    e = pick(16'hFE01, 16'h0001);
    accept_op(8'hFF, 8'hFF, e);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    for (int k = 0; k < 10; k++) begin
      check("hold_out_p", 64'(out_p), 64'(e));
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    total++;
    wait_outs(total);

    // Reset in the middle of a run.
    accept_op(8'h0B, 8'h0D, 16'h008F);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_core_rst", 64'(core_rst), 64'(1));
    seen = 0;
    repeat (30) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    check("abort_no_out", 64'(seen), 64'(0));
    out_count = 0;
    total = 0;
    @(posedge clk); #1;
    accept_op(8'h02, 8'h07, 16'h000E);
    in_valid = 1'b0;
    total++;
    wait_outs(total);

    // Back-to-back pairs with in_valid held high.
    a0 = acc_count;
    accept_op(8'd1, 8'd1, 16'h0001);
    accept_op(8'd0, 8'd200, 16'h0000);
    accept_op(8'd255, 8'd1, pick(16'h00FF, 16'hFFFF));
    in_valid = 1'b0;
    total += 3;
    wait_outs(total);
    check("b2b_accepts", 64'(acc_count - a0), 64'(3));

    // in_valid toggled during a run must be ignored.
    a0 = acc_count;
    accept_op(8'h04, 8'h06, 16'h0018);
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      in_valid = j[0];
      in_x = 8'h09;
      in_y = 8'h09;
      cur_exp = 16'hDEAD;
      @(negedge clk);
      check("ignore_core_x", 64'(core_x), 64'(8'h04));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    wait_outs(total);
    check("ignore_accepts", 64'(acc_count - a0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
